// File: rtl/microgreen_pkg.sv
// Shared types and defaults for the microgreen classifier sequencer.
// Holds the sequencer state encoding and the default frame/class geometry.
package microgreen_pkg;

  // Width of one sensor feature sample
  localparam int FEAT_W          = 8;

  // Default frame geometry and result width
  localparam int NUM_FEAT_DEF    = 4;
  localparam int CLASS_W_DEF     = 3;
  localparam int TIMEOUT_CYC_DEF = 255;

  // Sequencer states: gather a frame, fire the core, wait for its answer
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    START   = 2'd2,
    WAIT    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/microgreen_feat_buf.sv
// Indexed byte buffer that assembles a feature frame.
// Byte written with idx=k lands in feat[k*8 +: 8]; clr zeroes the whole frame.
module microgreen_feat_buf
  import microgreen_pkg::*;
#(
  parameter int NUM_FEAT = NUM_FEAT_DEF,
  parameter int IDX_W    = $clog2(NUM_FEAT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         we,
  input  logic [IDX_W-1:0]             idx,
  input  logic [FEAT_W-1:0]            data,
  output logic [NUM_FEAT*FEAT_W-1:0]   feat
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FEAT; gi++) begin : g_byte
      logic [FEAT_W-1:0] byte_reg;

      // Each byte lane captures data only when its own index is addressed
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          byte_reg <= '0;
        end else if (clr) begin
          byte_reg <= '0;
        end else if (we && (idx == IDX_W'(gi))) begin
          byte_reg <= data;
        end
      end

      assign feat[gi*FEAT_W +: FEAT_W] = byte_reg;
    end
  endgenerate

endmodule

// File: rtl/microgreen_seq_ctrl.sv
// Sequencer in front of the microgreen classifier core.
// Collects NUM_FEAT feature bytes over valid/ready, pulses cls_start, waits for
// cls_done and latches the class result. Dropping ena aborts to IDLE at once.
// Optional build macro SEQ_WATCHDOG_EN adds a WAIT-state watchdog that raises
// the sticky err_timeout flag after TIMEOUT_CYC cycles without cls_done; the
// flag clears on the first byte of the next frame.
module microgreen_seq_ctrl
  import microgreen_pkg::*;
#(
  parameter int NUM_FEAT    = NUM_FEAT_DEF,
  parameter int CLASS_W     = CLASS_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        feat_valid,
  input  logic [FEAT_W-1:0]           feat_data,
  output logic                        feat_ready,
  output logic                        cls_start,
  output logic [NUM_FEAT*FEAT_W-1:0]  cls_feat,
  input  logic                        cls_done,
  input  logic [CLASS_W-1:0]          cls_class,
  output logic                        res_valid,
  output logic [CLASS_W-1:0]          res_class,
  output logic                        busy,
  output logic                        err_timeout
);

  localparam int               IDX_W    = $clog2(NUM_FEAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  seq_state_t            state_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic                  res_valid_reg;
  logic [CLASS_W-1:0]    res_class_reg;
  logic                  transfer;

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]       wd_cnt_reg;
  logic                  err_timeout_reg;
`endif

  // Ready is also gated by reset so every output reads 0 while rst_n is low
  assign feat_ready = rst_n && ena && ((state_reg == IDLE) || (state_reg == COLLECT));
  assign transfer   = feat_valid && feat_ready;

  // Outputs decoded straight from the state register
  assign cls_start  = (state_reg == START);
  assign busy       = (state_reg == START) || (state_reg == WAIT);
  assign res_valid  = res_valid_reg;
  assign res_class  = res_class_reg;

`ifdef SEQ_WATCHDOG_EN
  assign err_timeout = err_timeout_reg;
`else
  assign err_timeout = 1'b0;
`endif

  // Frame assembly; an abort wipes the partially collected frame
  microgreen_feat_buf #(
    .NUM_FEAT (NUM_FEAT),
    .IDX_W    (IDX_W)
  ) u_feat_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!ena),
    .we    (transfer),
    .idx   (idx_reg),
    .data  (feat_data),
    .feat  (cls_feat)
  );

  // Sequencer FSM with result latch and optional watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      res_valid_reg   <= 1'b0;
      res_class_reg   <= '0;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt_reg      <= '0;
      err_timeout_reg <= 1'b0;
`endif
    end else if (!ena) begin
      // Abort beats everything, including a coincident cls_done
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (transfer) begin
            idx_reg   <= IDX_W'(1);
            state_reg <= COLLECT;
`ifdef SEQ_WATCHDOG_EN
            err_timeout_reg <= 1'b0;
`endif
          end
        end
        COLLECT: begin
          if (transfer) begin
            if (idx_reg == LAST_IDX) begin
              idx_reg   <= '0;
              state_reg <= START;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
        START: begin
          res_valid_reg <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
          wd_cnt_reg    <= '0;
`endif
          state_reg     <= WAIT;
        end
        WAIT: begin
          if (cls_done) begin
            res_class_reg <= cls_class;
            res_valid_reg <= 1'b1;
            state_reg     <= IDLE;
          end
`ifdef SEQ_WATCHDOG_EN
          else if (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1)) begin
            err_timeout_reg <= 1'b1;
            state_reg       <= IDLE;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_microgreen_seq_ctrl.sv
// Testbench for microgreen_seq_ctrl: scoreboard queues filled by the stimulus,
// drained by a monitor on cls_start / res_valid rising.
module tb_microgreen_seq_ctrl;

  localparam int NF = 4;
  localparam int CW = 3;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b0;
  logic              feat_valid = 1'b0;
  logic [7:0]        feat_data = '0;
  logic              feat_ready;
  logic              cls_start;
  logic [NF*8-1:0]   cls_feat;
  logic              cls_done = 1'b0;
  logic [CW-1:0]     cls_class = '0;
  logic              res_valid;
  logic [CW-1:0]     res_class;
  logic              busy;
  logic              err_timeout;

  microgreen_seq_ctrl #(
    .NUM_FEAT    (NF),
    .CLASS_W     (CW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .feat_valid  (feat_valid),
    .feat_data   (feat_data),
    .feat_ready  (feat_ready),
    .cls_start   (cls_start),
    .cls_feat    (cls_feat),
    .cls_done    (cls_done),
    .cls_class   (cls_class),
    .res_valid   (res_valid),
    .res_class   (res_class),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NF*8-1:0] exp_feat_q[$];
  logic [CW-1:0]   exp_res_q[$];
  logic            model_rv = 1'b0;
  logic [CW-1:0]   model_rc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte (optional idle gap first) and hold until it is accepted
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  n;
    bit  taken;
    n = 0;
    taken = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    feat_valid = 1'b1;
    feat_data  = b;
    while (!taken) begin
      @(negedge clk);
      if (feat_ready) taken = 1'b1;
      @(posedge clk);
      #1;
      n++;
      if (!taken && n > 20) begin
        check("ready_timeout", 64'd0, 64'd1);
        taken = 1'b1;
      end
    end
    feat_valid = 1'b0;
    feat_data  = 8'($urandom);
  endtask

  // Whole frame; returns positioned in the START cycle
  task automatic send_frame(input logic [NF*8-1:0] f, input bit gaps);
    exp_feat_q.push_back(f);
    for (int i = 0; i < NF; i++) send_byte(f[i*8 +: 8], gaps);
    check("start_latency", 64'(cls_start), 64'd1);
    check("busy_in_start", 64'(busy), 64'd1);
    check("ready_in_start", 64'(feat_ready), 64'd0);
  endtask

  // From START: deliver cls_done 'delay' cycles after the start cycle
  task automatic finish_frame(input int delay, input logic [CW-1:0] c);
    tick();
    check("start_width", 64'(cls_start), 64'd0);
    model_rv = 1'b0;
    check("res_valid_cleared", 64'(res_valid), 64'(model_rv));
    repeat (delay - 1) tick();
    cls_done  = 1'b1;
    cls_class = c;
    exp_res_q.push_back(c);
    tick();
    cls_done  = 1'b0;
    cls_class = CW'($urandom);
    model_rv = 1'b1;
    model_rc = c;
    check("busy_after_done", 64'(busy), 64'd0);
    check("ready_after_done", 64'(feat_ready), 64'd1);
  endtask

  function automatic logic [NF*8-1:0] rand_frame();
    logic [NF*8-1:0] f;
    for (int i = 0; i < NF; i++) f[i*8 +: 8] = 8'($urandom);
    return f;
  endfunction

  // Monitor: pops expectations when the DUT presents a start or a new result
  logic            prev_rv = 1'b0;
  logic [NF*8-1:0] cur_feat = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cls_start) begin
          if (exp_feat_q.size() == 0) begin
            check("unexpected_start", 64'd1, 64'd0);
          end else begin
            cur_feat = exp_feat_q.pop_front();
            check("cls_feat", 64'(cls_feat), 64'(cur_feat));
            $display("start  frame=%h", cls_feat);
          end
        end else if (busy) begin
          check("cls_feat_stable", 64'(cls_feat), 64'(cur_feat));
        end
        if (res_valid && !prev_rv) begin
          if (exp_res_q.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
          end else begin
            check("res_class", 64'(res_class), 64'(exp_res_q.pop_front()));
            $display("result class=%0d", res_class);
          end
        end
      end
      prev_rv = res_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NF*8-1:0] f;
    logic [CW-1:0]   c;
    int              mode;
    int              k;

    // Reset state
    #22;
    check("rst_feat_ready", 64'(feat_ready), 64'd0);
    check("rst_cls_start", 64'(cls_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_class", 64'(res_class), 64'd0);
    check("rst_cls_feat", 64'(cls_feat), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();
    check("idle_ready", 64'(feat_ready), 64'd1);

    // Directed frame, valid held, done 5 cycles after start with class 3
    send_frame(32'h44332211, 1'b0);
    check("directed_feat", 64'(cls_feat), 64'h44332211);
    finish_frame(5, 3'd3);
    check("directed_res_valid", 64'(res_valid), 64'd1);
    check("directed_res_class", 64'(res_class), 64'd3);

    // cls_done in IDLE is ignored
    cls_done = 1'b1; cls_class = 3'd5; tick(); cls_done = 1'b0;
    check("idle_done_rv", 64'(res_valid), 64'(model_rv));
    check("idle_done_rc", 64'(res_class), 64'(model_rc));
    check("idle_done_busy", 64'(busy), 64'd0);

    // Two bytes then abort: no start, then a fresh full frame from byte 0
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    ena = 1'b0;
    tick();
    check("abort_ready", 64'(feat_ready), 64'd0);
    check("abort_start", 64'(cls_start), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rv", 64'(res_valid), 64'(model_rv));
    ena = 1'b1;
    tick();
    check("abort_no_start", 64'(cls_start), 64'd0);
    f = rand_frame();
    send_frame(f, 1'b1);
    finish_frame(2, 3'd6);

    // cls_done during COLLECT is ignored
    f = rand_frame();
    exp_feat_q.push_back(f);
    send_byte(f[7:0], 1'b0);
    cls_done = 1'b1; cls_class = ~model_rc; tick(); cls_done = 1'b0;
    check("collect_done_rv", 64'(res_valid), 64'(model_rv));
    check("collect_done_rc", 64'(res_class), 64'(model_rc));
    for (int i = 1; i < NF; i++) send_byte(f[i*8 +: 8], 1'b1);
    check("start_latency2", 64'(cls_start), 64'd1);
    finish_frame(1, CW'($urandom));

    // Randomized frames: normal, abort mid-collect, abort+done in WAIT
    for (int n = 0; n < 24; n++) begin
      mode = $urandom_range(0, 9);
      f = rand_frame();
      c = CW'($urandom);
      if (mode == 0) begin
        send_frame(f, 1'b1);
        tick();
        model_rv = 1'b0;
        repeat ($urandom_range(0, 4)) tick();
        ena = 1'b0; cls_done = 1'b1; cls_class = c;
        tick();
        ena = 1'b1; cls_done = 1'b0;
        check("wait_abort_busy", 64'(busy), 64'd0);
        check("wait_abort_rv", 64'(res_valid), 64'(model_rv));
      end else if (mode == 1) begin
        k = $urandom_range(1, NF - 1);
        for (int i = 0; i < k; i++) send_byte(f[i*8 +: 8], 1'b1);
        ena = 1'b0;
        tick();
        ena = 1'b1;
        check("collect_abort_start", 64'(cls_start), 64'd0);
        check("collect_abort_rv", 64'(res_valid), 64'(model_rv));
      end else begin
        send_frame(f, 1'b1);
        finish_frame($urandom_range(1, 10), c);
        check("rand_res_class", 64'(res_class), 64'(model_rc));
      end
    end

`ifdef SEQ_WATCHDOG_EN
    // Watchdog: no done -> error after TO WAIT cycles, cleared on next byte
    f = rand_frame();
    send_frame(f, 1'b0);
    model_rv = 1'b0;
    repeat (TO) tick();
    check("wd_busy_before", 64'(busy), 64'd1);
    check("wd_err_before", 64'(err_timeout), 64'd0);
    tick();
    check("wd_err", 64'(err_timeout), 64'd1);
    check("wd_busy_after", 64'(busy), 64'd0);
    check("wd_rv", 64'(res_valid), 64'(model_rv));
    f = rand_frame();
    exp_feat_q.push_back(f);
    send_byte(f[7:0], 1'b0);
    check("wd_err_cleared", 64'(err_timeout), 64'd0);
    for (int i = 1; i < NF; i++) send_byte(f[i*8 +: 8], 1'b0);
    finish_frame(3, 3'd1);
`else
    // Without watchdog WAIT lasts until done
    f = rand_frame();
    send_frame(f, 1'b0);
    repeat (300) tick();
    check("long_wait_busy", 64'(busy), 64'd1);
    check("long_wait_err", 64'(err_timeout), 64'd0);
    cls_done = 1'b1; cls_class = 3'd2; exp_res_q.push_back(3'd2);
    tick();
    cls_done = 1'b0;
    model_rv = 1'b1; model_rc = 3'd2;
    check("long_wait_done", 64'(busy), 64'd0);
`endif

    // Asynchronous reset in the middle of WAIT
    f = rand_frame();
    send_frame(f, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_rv = 1'b0;
    model_rc = '0;
    check("arst_ready", 64'(feat_ready), 64'd0);
    check("arst_start", 64'(cls_start), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_rv", 64'(res_valid), 64'(model_rv));
    check("arst_rc", 64'(res_class), 64'(model_rc));
    check("arst_feat", 64'(cls_feat), 64'd0);
    check("arst_err", 64'(err_timeout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_release_ready", 64'(feat_ready), 64'd1);
    tick();
    f = rand_frame();
    send_frame(f, 1'b1);
    finish_frame(4, 3'd7);

    repeat (3) tick();
    check("feat_queue_empty", 64'(exp_feat_q.size()), 64'd0);
    check("res_queue_empty", 64'(exp_res_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
